// File: rtl/spike_event_logger.sv
// Spike rising-edge event logger: timestamps pre/post edges into a FIFO; 1-cycle write-to-valid latency.
// Valid/ready output; a full FIFO with no pop that cycle drops the event and counts it (saturating).
module spike_event_logger #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 14
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     clr,
  input  logic                     pre_spike,
  input  logic                     post_spike,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [TS_W+1:0]          out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               drop_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = TS_W + 2;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [TS_W-1:0] ts;
  logic            pre_q;
  logic            post_q;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   cnt;

  logic            pre_edge;
  logic            post_edge;
  logic            ev;
  logic            full;
  logic            empty;
  logic            pop;
  logic            push;
  logic            drop;
  logic [EW-1:0]   ev_word;

  always_comb begin
    pre_edge  = pre_spike & ~pre_q;
    post_edge = post_spike & ~post_q;
    ev        = enable & (pre_edge | post_edge);
    ev_word   = {post_edge, pre_edge, ts};
    full      = (cnt == FULL_LVL);
    empty     = (cnt == '0);
    pop       = ~empty & out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push      = ev & (~full | pop);
    drop      = ev & full & ~pop;
  end

  assign out_valid = ~empty;
  assign out_data  = empty ? '0 : mem[rd_ptr];
  assign level     = cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts <= '0;
    end else if (clr) begin
      ts <= '0;
    end else begin
      ts <= ts + 1'b1;
    end
  end

  // Edge history keeps tracking through clr and enable=0 so held levels never re-fire.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q  <= 1'b0;
      post_q <= 1'b0;
    end else begin
      pre_q  <= pre_spike;
      post_q <= post_spike;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!clr && push) begin
      mem[wr_ptr] <= ev_word;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (clr) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (drop) begin
      if (drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spike_event_logger.sv
// Directed bench for spike_event_logger: hand-computed event words, FIFO order, drops, wrap, clr and reset.
module tb_spike_event_logger;
  localparam int DEPTH = 8;
  localparam int TS_W  = 14;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        clr = 1'b0;
  logic        pre_spike = 1'b0;
  logic        post_spike = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [3:0]  level;
  logic [7:0]  drop_count;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  spike_event_logger #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .clr        (clr),
    .pre_spike  (pre_spike),
    .post_spike (post_spike),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .level      (level),
    .drop_count (drop_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_pre();
    pre_spike = 1'b1;
    tick();
    pre_spike = 1'b0;
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    enable = 1'b1;
    #12;
    check("rst_level", level, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_drop", drop_count, 0);
    check("rst_ovf", overflow, 0);

    // Release between edges; edge k after release samples timestamp k.
    @(negedge clk);
    reset_n = 1'b1;
    ticks(5);
    pre_spike = 1'b1;
    check("pre_latency_valid", out_valid, 0);
    tick();
    check("ts5_valid", out_valid, 1);
    check("ts5_data", out_data, 16'h4005);
    check("ts5_level", level, 1);
    ticks(2);
    pre_spike = 1'b0;
    tick();
    check("held_one_event_level", level, 1);
    check("held_one_event_data", out_data, 16'h4005);

    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pop_level", level, 0);
    check("empty_data_zero", out_data, 0);

    // Both spikes at timestamp 20.
    clr = 1'b1; tick(); clr = 1'b0;
    ticks(20);
    pre_spike = 1'b1; post_spike = 1'b1;
    tick();
    pre_spike = 1'b0; post_spike = 1'b0;
    check("both_data", out_data, 16'hC014);
    check("both_level", level, 1);
    tick();
    check("both_single_entry", level, 1);

    // Ten isolated pre edges at timestamps 0,2,..,18 into an 8-deep FIFO.
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_level", level, 0);
    repeat (10) pulse_pre();
    check("full_level", level, 8);
    check("full_drop", drop_count, 2);
    check("full_ovf", overflow, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_%0d", i), out_data, 32'h4000 + 2 * i);
      tick();
    end
    check("drained_valid", out_valid, 0);
    check("drained_level", level, 0);
    check("drop_kept", drop_count, 2);

    // Push into empty FIFO while out_ready is high: not popped at that edge.
    pre_spike = 1'b1;
    tick();
    pre_spike = 1'b0;
    check("empty_push_ready_level", level, 1);
    check("empty_push_ready_code", out_data[15:14], 2'b01);
    tick();
    check("empty_push_ready_popped", level, 0);
    out_ready = 1'b0;

    // Full FIFO, simultaneous pop and post push at timestamp 18.
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (9) pulse_pre();
    check("full2_level", level, 8);
    check("full2_drop", drop_count, 1);
    post_spike = 1'b1;
    out_ready = 1'b1;
    tick();
    post_spike = 1'b0;
    check("pushpop_full_level", level, 8);
    check("pushpop_full_drop", drop_count, 1);
    for (int i = 1; i < 8; i++) begin
      check($sformatf("pushpop_order_%0d", i), out_data, 32'h4000 + 2 * i);
      tick();
    end
    check("pushpop_last", out_data, 16'h8012);
    tick();
    check("pushpop_empty", out_valid, 0);
    out_ready = 1'b0;

    // Drop counter saturation.
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_drop", drop_count, 0);
    check("clr_ovf", overflow, 0);
    repeat (8 + 260) pulse_pre();
    check("sat_drop", drop_count, 255);
    check("sat_ovf", overflow, 1);
    check("sat_level", level, 8);

    // Timestamp wrap: edges at 16383 and 1.
    clr = 1'b1; tick(); clr = 1'b0;
    ticks(16383);
    pre_spike = 1'b1; tick();
    pre_spike = 1'b0; tick();
    pre_spike = 1'b1; tick();
    pre_spike = 1'b0;
    check("wrap_level", level, 2);
    check("wrap_first", out_data, 16'h7FFF);
    out_ready = 1'b1;
    tick();
    check("wrap_second", out_data, 16'h4001);
    tick();
    check("wrap_empty", out_valid, 0);
    out_ready = 1'b0;

    // enable low: no entries, no drop accounting, pops continue.
    clr = 1'b1; tick(); clr = 1'b0;
    enable = 1'b0;
    repeat (3) pulse_pre();
    post_spike = 1'b1; tick(); post_spike = 1'b0; tick();
    check("dis_level", level, 0);
    check("dis_valid", out_valid, 0);
    check("dis_drop", drop_count, 0);
    enable = 1'b1;
    repeat (8) pulse_pre();
    check("en_fill_level", level, 8);
    enable = 1'b0;
    repeat (3) pulse_pre();
    check("dis_full_level", level, 8);
    check("dis_full_drop", drop_count, 0);
    check("dis_full_ovf", overflow, 0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("dis_pop_level", level, 7);
    pre_spike = 1'b1; tick();
    enable = 1'b1; tick();
    pre_spike = 1'b0; tick();
    check("held_across_enable", level, 7);

    // clr with three entries; timestamp restarts at 0.
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (3) pulse_pre();
    check("clr3_level_before", level, 3);
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr3_valid", out_valid, 0);
    check("clr3_level", level, 0);
    check("clr3_data", out_data, 0);
    pre_spike = 1'b1; tick(); pre_spike = 1'b0;
    check("clr3_ts_restart", out_data, 16'h4000);
    check("clr3_level_after", level, 1);

    // Asynchronous reset mid-operation, spike already high at release.
    reset_n = 1'b0;
    #1;
    check("arst_level", level, 0);
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    post_spike = 1'b1;
    ticks(2);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("rel_high_level", level, 1);
    check("rel_high_data", out_data, 16'h8000);
    post_spike = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spike_event_logger.md
SPIKE_EVENT_LOGGER -- requirements
Module: spike_event_logger

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TS_W, default 14, meaning timestamp width; event word width is TS_W+2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  high: detected events are logged; low: events discarded, not counted as drops.
REQ-006 clr  input  1  synchronous flush of FIFO, timestamp, drop counter and overflow flag.
REQ-007 pre_spike  input  1  level spike from upstream (pre-synaptic) neuron.
REQ-008 post_spike  input  1  level spike from downstream (post-synaptic) neuron.
REQ-009 out_ready  input  1  consumer accepts the head event this cycle.
REQ-010 out_valid  output  1  FIFO not empty; head event presented.
REQ-011 out_data  output  TS_W+2  head event: [TS_W+1:TS_W] source code, [TS_W-1:0] timestamp.
REQ-012 level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-013 drop_count  output  8  number of events lost to a full FIFO, saturating at 255.
REQ-014 overflow  output  1  sticky; set on first dropped event.

Function
REQ-015 SHALL hold a free-running TS_W-bit timestamp incremented every cycle, wrapping 2^TS_W-1 -> 0, independent of enable.
REQ-016 SHALL register previous pre_spike and post_spike each cycle; an event is a rising edge (current 1, registered previous 0).
REQ-017 Held-high spike levels SHALL produce exactly one event per rising edge.
REQ-018 Source code SHALL be 2'b01 pre only, 2'b10 post only, 2'b11 both edges same cycle (one FIFO entry, never two).
REQ-019 Event timestamp SHALL equal the timestamp register value at the clock edge where the rising edge is sampled (pre-increment value).
REQ-020 Event SHALL be written at that same edge; out_valid SHALL rise after that edge if the FIFO was empty (1-cycle latency, no combinational bypass).
REQ-021 Pop SHALL occur at an edge where out_valid and out_ready are both high; out_data SHALL be the oldest entry (FIFO order).
REQ-022 out_data SHALL be all zeros whenever out_valid is low.
REQ-023 Push when full and no pop same cycle: event dropped, drop_count += 1 (saturate at 255), overflow set.
REQ-024 Push and pop same cycle when full: both SHALL occur; no drop; level unchanged.
REQ-025 Push and pop same cycle at level 1..DEPTH-1: level unchanged, order preserved.
REQ-026 Push on empty with out_ready high: no pop that cycle (out_valid was low); entry appears next cycle.
REQ-027 enable low: edge detector registers still update; no push, no drop accounting; pops continue.
REQ-028 clr SHALL take priority over push/pop that cycle: level 0, timestamp 0, drop_count 0, overflow 0; edge registers keep updating.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH; level distinguishes full from empty.

Reset
REQ-030 On reset_n low, asynchronously: timestamp 0, previous-spike registers 0, pointers 0, level 0, out_valid 0, out_data 0, drop_count 0, overflow 0.
REQ-031 A spike input already high when reset_n deasserts SHALL produce an event at the first active edge (previous register is 0).
REQ-032 Reset mid-operation SHALL discard all buffered events; no partial state survives.

Verification
REQ-033 Reset release, enable=1, pre_spike rises at timestamp 5, held 3 cycles, out_ready=0 -> one entry, out_data=16'h4005, level 1.
REQ-034 pre_spike and post_spike rise together at timestamp 20 -> single entry 16'hC014.
REQ-035 out_ready=0, 10 isolated pre edges -> level 8, drop_count 2, overflow 1; then out_ready=1 drains 8 entries in order, first 8 timestamps.
REQ-036 FIFO full, out_ready=1, new post edge same cycle -> level stays 8, drop_count unchanged, new entry last in order.
REQ-037 Timestamp at 16383, pre edge, then pre edge one cycle after next rising -> entries timestamps 16383 then wrapped value 0x0001 region, no corruption.
REQ-038 enable=0 spikes -> no entries, drop_count 0; clr with 3 entries -> out_valid 0, level 0 next cycle, timestamp restarts at 0.
